// File: rtl/ysyx_24100006_wbu.sv
// Writeback unit: round-robin arbitration between EXU results and LSU loads, load
// extension/alignment, one registered GPR write port, and a destination scoreboard.
module ysyx_24100006_wbu #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic [1:0]            lsu_size,
    input  logic                  lsu_unsigned,
    input  logic [1:0]            lsu_addr_lo,
    output logic                  gpr_wen,
    output logic [ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_next;
    logic                  last_lsu;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;

    always_comb begin
        byte_lane = lsu_data[7:0];
        case (lsu_addr_lo)
            2'd0: byte_lane = lsu_data[7:0];
            2'd1: byte_lane = lsu_data[15:8];
            2'd2: byte_lane = lsu_data[23:16];
            2'd3: byte_lane = lsu_data[31:24];
            default: byte_lane = lsu_data[7:0];
        endcase
        half_lane = lsu_addr_lo[1] ? lsu_data[31:16] : lsu_data[15:0];
        case (lsu_size)
            2'd0:    load_data = {{(DATA_WIDTH-8){~lsu_unsigned & byte_lane[7]}}, byte_lane};
            2'd1:    load_data = {{(DATA_WIDTH-16){~lsu_unsigned & half_lane[15]}}, half_lane};
            default: load_data = lsu_data;
        endcase
    end

    // On a tie the source that did not win last time gets the grant.
    assign exu_ready = exu_valid & (~lsu_valid | last_lsu);
    assign lsu_ready = lsu_valid & (~exu_valid | ~last_lsu);
    assign accept    = exu_ready | lsu_ready;
    assign win_rd    = lsu_ready ? lsu_rd : exu_rd;
    assign win_data  = lsu_ready ? load_data : exu_data;

    assign iss_ready = (iss_rd == '0) | ~busy[iss_rd];
    assign rs1_busy  = (rs1 != '0) & busy[rs1];
    assign rs2_busy  = (rs2 != '0) & busy[rs2];

    // Commit clears first so that a same-edge issue of the same index wins.
    always_comb begin
        busy_next = busy;
        if (gpr_wen)
            busy_next[gpr_waddr] = 1'b0;
        if (iss_valid && iss_ready && (iss_rd != '0))
            busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= '0;
            last_lsu  <= 1'b0;
            gpr_wen   <= 1'b0;
            gpr_waddr <= '0;
            gpr_wdata <= '0;
        end else begin
            busy <= busy_next;
            if (accept)
                last_lsu <= lsu_ready;
            if (accept && (win_rd != '0)) begin
                gpr_wen   <= 1'b1;
                gpr_waddr <= win_rd;
                gpr_wdata <= win_data;
            end else begin
                gpr_wen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Directed bench for ysyx_24100006_wbu: a table of single beats (load formatting,
// output hold) plus sequences for arbitration, scoreboard hazards and reset.
module tb_ysyx_24100006_wbu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_ready;
    logic [3:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        exu_valid, exu_ready;
    logic [3:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [3:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [1:0]  lsu_addr_lo;
    logic        gpr_wen;
    logic [3:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ysyx_24100006_wbu dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_addr_lo(lsu_addr_lo),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata)
    );

    typedef struct {
        logic        is_lsu;
        logic [3:0]  rd;
        logic [31:0] data;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lo;
        logic        exp_wen;
        logic [3:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
        exu_valid = 0; exu_rd = 0; exu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        lsu_size = 0; lsu_unsigned = 0; lsu_addr_lo = 0;
    endtask

    task automatic doReset();
        idleInputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic applyStimulus(input vec_t v);
        exu_valid    = !v.is_lsu;
        lsu_valid    = v.is_lsu;
        exu_rd       = v.rd;
        lsu_rd       = v.rd;
        exu_data     = v.data;
        lsu_data     = v.data;
        lsu_size     = v.size;
        lsu_unsigned = v.uns;
        lsu_addr_lo  = v.lo;
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'd5,  32'h1234_5678, 2'd0, 1'b0, 2'd0, 1'b1, 4'd5,  32'h1234_5678};
        vecs[1] = '{1'b1, 4'd6,  32'h80FF_7F01, 2'd0, 1'b0, 2'd3, 1'b1, 4'd6,  32'hFFFF_FF80};
        vecs[2] = '{1'b1, 4'd7,  32'h80FF_7F01, 2'd0, 1'b1, 2'd1, 1'b1, 4'd7,  32'h0000_007F};
        vecs[3] = '{1'b1, 4'd8,  32'h80FF_7F01, 2'd1, 1'b0, 2'd2, 1'b1, 4'd8,  32'hFFFF_80FF};
        vecs[4] = '{1'b1, 4'd9,  32'h80FF_7F01, 2'd1, 1'b1, 2'd0, 1'b1, 4'd9,  32'h0000_7F01};
        vecs[5] = '{1'b1, 4'd10, 32'h80FF_7F01, 2'd2, 1'b0, 2'd1, 1'b1, 4'd10, 32'h80FF_7F01};
        vecs[6] = '{1'b1, 4'd11, 32'h80FF_7F01, 2'd3, 1'b1, 2'd2, 1'b1, 4'd11, 32'h80FF_7F01};
        vecs[7] = '{1'b0, 4'd0,  32'hDEAD_BEEF, 2'd0, 1'b0, 2'd0, 1'b0, 4'd11, 32'h80FF_7F01};
        vecs[8] = '{1'b1, 4'd12, 32'h80FF_7F01, 2'd0, 1'b0, 2'd2, 1'b1, 4'd12, 32'hFFFF_FFFF};
        vecs[9] = '{1'b1, 4'd13, 32'h80FF_7F01, 2'd1, 1'b1, 2'd3, 1'b1, 4'd13, 32'h0000_80FF};

        rst_n = 0;
        idleInputs();
        #1;
        doReset();

        checkOutput("reset_wen",   {31'd0, gpr_wen}, 32'd0);
        checkOutput("reset_waddr", {28'd0, gpr_waddr}, 32'd0);
        checkOutput("reset_wdata", gpr_wdata, 32'd0);
        iss_rd = 4'd9; rs1 = 4'd5; rs2 = 4'd15;
        #1;
        checkOutput("reset_iss_ready", {31'd0, iss_ready}, 32'd1);
        checkOutput("reset_rs1_busy",  {31'd0, rs1_busy}, 32'd0);
        checkOutput("reset_rs2_busy",  {31'd0, rs2_busy}, 32'd0);
        idleInputs();

        // Single beats: accept, one-cycle write pulse, then hold.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkOutput($sformatf("v%0d_ready", i),
                        {31'd0, vecs[i].is_lsu ? lsu_ready : exu_ready}, 32'd1);
            tick();
            checkOutput($sformatf("v%0d_wen", i),   {31'd0, gpr_wen}, {31'd0, vecs[i].exp_wen});
            checkOutput($sformatf("v%0d_waddr", i), {28'd0, gpr_waddr}, {28'd0, vecs[i].exp_waddr});
            checkOutput($sformatf("v%0d_wdata", i), gpr_wdata, vecs[i].exp_wdata);
            idleInputs();
            tick();
            checkOutput($sformatf("v%0d_wen_off", i), {31'd0, gpr_wen}, 32'd0);
            checkOutput($sformatf("v%0d_hold", i),    gpr_wdata, vecs[i].exp_wdata);
        end

        // Round-robin: both sources continuously valid, LSU wins the first tie.
        doReset();
        exu_valid = 1; exu_rd = 4'd1; exu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 4'd2; lsu_data = 32'h22; lsu_size = 2'd2;
        for (int k = 0; k < 4; k++) begin
            #3;
            checkOutput($sformatf("rr%0d_lsu_ready", k), {31'd0, lsu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr%0d_exu_ready", k), {31'd0, exu_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            checkOutput($sformatf("rr%0d_waddr", k), {28'd0, gpr_waddr}, (k % 2 == 0) ? 32'd2 : 32'd1);
            checkOutput($sformatf("rr%0d_wen", k),   {31'd0, gpr_wen}, 32'd1);
        end
        idleInputs();
        tick();

        // RAW/WAW hazard on rd=7.
        iss_valid = 1; iss_rd = 4'd7;
        #3;
        checkOutput("iss7_ready_first", {31'd0, iss_ready}, 32'd1);
        tick();
        rs1 = 4'd7; rs2 = 4'd7;
        exu_valid = 1; exu_rd = 4'd7; exu_data = 32'h77;
        #3;
        checkOutput("iss7_rs1_busy", {31'd0, rs1_busy}, 32'd1);
        checkOutput("iss7_rs2_busy", {31'd0, rs2_busy}, 32'd1);
        checkOutput("iss7_blocked",  {31'd0, iss_ready}, 32'd0);
        tick();
        exu_valid = 0;
        #3;
        checkOutput("iss7_commit_wen", {31'd0, gpr_wen}, 32'd1);
        checkOutput("iss7_blocked_n1", {31'd0, iss_ready}, 32'd0);
        checkOutput("iss7_busy_n1",    {31'd0, rs1_busy}, 32'd1);
        tick();
        iss_valid = 0;
        #1;
        checkOutput("iss7_busy_n2",  {31'd0, rs1_busy}, 32'd0);
        checkOutput("iss7_ready_n2", {31'd0, iss_ready}, 32'd1);
        tick();

        // Issue and writeback to x0 leave the scoreboard untouched.
        iss_valid = 1; iss_rd = 4'd0; rs1 = 4'd0;
        exu_valid = 1; exu_rd = 4'd0; exu_data = 32'hDEAD_BEEF;
        #3;
        checkOutput("x0_iss_ready", {31'd0, iss_ready}, 32'd1);
        checkOutput("x0_exu_ready", {31'd0, exu_ready}, 32'd1);
        tick();
        idleInputs();
        #1;
        checkOutput("x0_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        checkOutput("x0_wen",      {31'd0, gpr_wen}, 32'd0);
        tick();

        // Same-edge set and clear of index 4: set wins.
        exu_valid = 1; exu_rd = 4'd4; exu_data = 32'h44;
        tick();
        exu_valid = 0;
        iss_valid = 1; iss_rd = 4'd4; rs1 = 4'd4;
        #3;
        checkOutput("setwin_wen", {31'd0, gpr_wen}, 32'd1);
        tick();
        iss_valid = 0;
        #1;
        checkOutput("setwin_busy", {31'd0, rs1_busy}, 32'd1);

        // Reset while a write to rd=3 is in the output stage.
        doReset();
        iss_valid = 1; iss_rd = 4'd3;
        tick();
        iss_valid = 0;
        exu_valid = 1; exu_rd = 4'd3; exu_data = 32'h33;
        tick();
        exu_valid = 0; rs1 = 4'd3; iss_rd = 4'd3;
        #1;
        checkOutput("rst3_wen_before", {31'd0, gpr_wen}, 32'd1);
        checkOutput("rst3_busy_before", {31'd0, rs1_busy}, 32'd1);
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        checkOutput("rst3_wen",   {31'd0, gpr_wen}, 32'd0);
        checkOutput("rst3_busy",  {31'd0, rs1_busy}, 32'd0);
        checkOutput("rst3_ready", {31'd0, iss_ready}, 32'd1);
        checkOutput("rst3_waddr", {28'd0, gpr_waddr}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
